// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_unit
// Brief  : ID-stage opcode decode feeding the ID/EX, EX/MEM and MEM/WB
//          control registers, with stall/flush bubbles and halt-and-drain FSM.
// Rev    : 1.0  initial pipelined release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int OPCODE_W     = 7,
    parameter int ENABLE_UPPER = 1,
    parameter int ILL_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  id_opcode,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ex_alu_src,
    output logic                 ex_branch,
    output logic                 ex_jal_sel,
    output logic [1:0]           ex_alu_op,
    output logic [1:0]           ex_upper,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic                 halted,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [OPCODE_W-1:0] c_OP_R     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] c_OP_I     = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] c_OP_LW    = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] c_OP_SW    = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] c_OP_BR    = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] c_OP_JAL   = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] c_OP_JALR  = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] c_OP_HALT  = OPCODE_W'(7'b1111111);
    localparam logic [OPCODE_W-1:0] c_OP_LUI   = OPCODE_W'(7'b0110111);
    localparam logic [OPCODE_W-1:0] c_OP_AUIPC = OPCODE_W'(7'b0010111);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [1:0] c_DRAIN_LOAD = 2'd2;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_upper_en;
    logic       w_dec_legal;
    logic       w_dec_halt;
    logic       w_dec_alu_src;
    logic       w_dec_branch;
    logic       w_dec_jal_sel;
    logic [1:0] w_dec_alu_op;
    logic [1:0] w_dec_upper;
    logic       w_dec_mem_read;
    logic       w_dec_mem_write;
    logic       w_dec_reg_write;
    logic       w_dec_mem_to_reg;

    generate
        if (ENABLE_UPPER != 0) begin : g_upper_on
            assign w_upper_en = 1'b1;
        end else begin : g_upper_off
            assign w_upper_en = 1'b0;
        end
    endgenerate

    always_comb begin
        w_dec_legal      = 1'b0;
        w_dec_halt       = 1'b0;
        w_dec_alu_src    = 1'b0;
        w_dec_branch     = 1'b0;
        w_dec_jal_sel    = 1'b0;
        w_dec_alu_op     = 2'b00;
        w_dec_upper      = 2'b00;
        w_dec_mem_read   = 1'b0;
        w_dec_mem_write  = 1'b0;
        w_dec_reg_write  = 1'b0;
        w_dec_mem_to_reg = 1'b0;
        case (id_opcode)
            c_OP_R: begin
                w_dec_legal     = 1'b1;
                w_dec_alu_op    = 2'b10;
                w_dec_reg_write = 1'b1;
            end
            c_OP_I: begin
                w_dec_legal     = 1'b1;
                w_dec_alu_src   = 1'b1;
                w_dec_alu_op    = 2'b10;
                w_dec_reg_write = 1'b1;
            end
            c_OP_LW: begin
                w_dec_legal      = 1'b1;
                w_dec_alu_src    = 1'b1;
                w_dec_mem_read   = 1'b1;
                w_dec_reg_write  = 1'b1;
                w_dec_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_dec_legal     = 1'b1;
                w_dec_alu_src   = 1'b1;
                w_dec_mem_write = 1'b1;
            end
            c_OP_BR: begin
                w_dec_legal  = 1'b1;
                w_dec_alu_op = 2'b01;
                w_dec_branch = 1'b1;
            end
            c_OP_JAL: begin
                w_dec_legal     = 1'b1;
                w_dec_branch    = 1'b1;
                w_dec_jal_sel   = 1'b1;
                w_dec_reg_write = 1'b1;
            end
            c_OP_JALR: begin
                w_dec_legal     = 1'b1;
                w_dec_jal_sel   = 1'b1;
                w_dec_reg_write = 1'b1;
            end
            c_OP_HALT: begin
                w_dec_legal = 1'b1;
                w_dec_halt  = 1'b1;
            end
            c_OP_LUI: begin
                if (w_upper_en) begin
                    w_dec_legal     = 1'b1;
                    w_dec_alu_src   = 1'b1;
                    w_dec_upper     = 2'b01;
                    w_dec_reg_write = 1'b1;
                end
            end
            c_OP_AUIPC: begin
                if (w_upper_en) begin
                    w_dec_legal     = 1'b1;
                    w_dec_alu_src   = 1'b1;
                    w_dec_upper     = 2'b10;
                    w_dec_reg_write = 1'b1;
                end
            end
            default: begin
                w_dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Halt FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_drain_cnt;
    logic [1:0] w_drain_nxt;
    logic       w_run;
    logic       w_take_halt;
    logic       w_any_valid;
    logic       r_ex_valid;
    logic       r_mem_valid;
    logic       r_wb_valid;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_take_halt = w_run & id_valid & w_dec_halt & ~stall & ~flush;
    assign w_any_valid = r_ex_valid | r_mem_valid | r_wb_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (w_take_halt) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_drain_nxt = c_DRAIN_LOAD;
                end
            end
            c_ST_DRAIN: begin
                // The counter covers the two older instructions still in flight.
                if (r_drain_cnt != 2'd0) begin
                    w_drain_nxt = r_drain_cnt - 2'd1;
                end else if (!w_any_valid) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic       w_idex_load;
    logic       r_ex_alu_src;
    logic       r_ex_branch;
    logic       r_ex_jal_sel;
    logic [1:0] r_ex_alu_op;
    logic [1:0] r_ex_upper;
    logic       r_ex_mem_read;
    logic       r_ex_mem_write;
    logic       r_ex_reg_write;
    logic       r_ex_mem_to_reg;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_mem_reg_write;
    logic       r_mem_mem_to_reg;
    logic       r_wb_reg_write;
    logic       r_wb_mem_to_reg;

    // Anything other than a legal non-HALT opcode in RUN with no hazard is a bubble.
    assign w_idex_load = w_run & id_valid & ~stall & ~flush & w_dec_legal & ~w_dec_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_alu_src    <= 1'b0;
            r_ex_branch     <= 1'b0;
            r_ex_jal_sel    <= 1'b0;
            r_ex_alu_op     <= 2'b00;
            r_ex_upper      <= 2'b00;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end else if (w_idex_load) begin
            r_ex_valid      <= 1'b1;
            r_ex_alu_src    <= w_dec_alu_src;
            r_ex_branch     <= w_dec_branch;
            r_ex_jal_sel    <= w_dec_jal_sel;
            r_ex_alu_op     <= w_dec_alu_op;
            r_ex_upper      <= w_dec_upper;
            r_ex_mem_read   <= w_dec_mem_read;
            r_ex_mem_write  <= w_dec_mem_write;
            r_ex_reg_write  <= w_dec_reg_write;
            r_ex_mem_to_reg <= w_dec_mem_to_reg;
        end else begin
            r_ex_valid      <= 1'b0;
            r_ex_alu_src    <= 1'b0;
            r_ex_branch     <= 1'b0;
            r_ex_jal_sel    <= 1'b0;
            r_ex_alu_op     <= 2'b00;
            r_ex_upper      <= 2'b00;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
        end else begin
            r_mem_valid      <= r_ex_valid;
            r_mem_read       <= r_ex_mem_read;
            r_mem_write      <= r_ex_mem_write;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_wb_valid       <= r_mem_valid;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
        end
    end

    // ------------------------------------------------------------------
    // Illegal-opcode counter
    // ------------------------------------------------------------------
    logic [ILL_CNT_W-1:0] r_ill_count;
    logic                 w_ill_inc;

    assign w_ill_inc = w_run & id_valid & ~stall & ~flush & ~w_dec_legal &
                       (r_ill_count != {ILL_CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_count <= '0;
        end else if (w_ill_inc) begin
            r_ill_count <= r_ill_count + ILL_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_out_en;
    logic w_ex_en;
    logic w_mem_en;
    logic w_wb_en;

    assign w_out_en = (r_state != c_ST_HALTED);
    assign w_ex_en  = w_out_en & r_ex_valid;
    assign w_mem_en = w_out_en & r_mem_valid;
    assign w_wb_en  = w_out_en & r_wb_valid;

    assign pc_write      = w_run & ~stall;
    assign ifid_write    = w_run & ~stall;
    assign ex_alu_src    = w_ex_en & r_ex_alu_src;
    assign ex_branch     = w_ex_en & r_ex_branch;
    assign ex_jal_sel    = w_ex_en & r_ex_jal_sel;
    assign ex_alu_op     = {2{w_ex_en}} & r_ex_alu_op;
    assign ex_upper      = {2{w_ex_en}} & r_ex_upper;
    assign mem_read      = w_mem_en & r_mem_read;
    assign mem_write     = w_mem_en & r_mem_write;
    assign wb_reg_write  = w_wb_en & r_wb_reg_write;
    assign wb_mem_to_reg = w_wb_en & r_wb_mem_to_reg;
    assign halted        = (r_state == c_ST_HALTED);
    assign ill_count     = r_ill_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_ctrl_unit
// Brief  : Scoreboard bench for pipe_ctrl_unit; two instances (upper opcodes
//          enabled / disabled) share one randomized + directed stimulus stream.
// Rev    : 1.0
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       alu_src, branch, jal_sel;
        logic [1:0] alu_op, upper;
        logic       mem_read, mem_write, reg_write, mem_to_reg;
    } ctl_t;

    typedef struct packed {
        logic [7:0] ill;
        logic       halted;
        logic [1:0] fetch;   // {pc_write, ifid_write}
        logic [6:0] ex;      // {alu_src, branch, jal_sel, alu_op, upper}
        logic [1:0] mem;     // {mem_read, mem_write}
        logic [1:0] wb;      // {reg_write, mem_to_reg}
    } obs_t;

    typedef struct packed {
        obs_t u1;
        obs_t u0;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] id_opcode;
    logic       id_valid;
    logic       stall;
    logic       flush;

    logic       u0_pcw, u0_ifw, u0_alu_src, u0_branch, u0_jal_sel, u0_mr, u0_mw, u0_wr, u0_wm, u0_halted;
    logic [1:0] u0_alu_op, u0_upper;
    logic [7:0] u0_ill;
    logic       u1_pcw, u1_ifw, u1_alu_src, u1_branch, u1_jal_sel, u1_mr, u1_mw, u1_wr, u1_wm, u1_halted;
    logic [1:0] u1_alu_op, u1_upper;
    logic [7:0] u1_ill;

    pipe_ctrl_unit #(.OPCODE_W(7), .ENABLE_UPPER(0), .ILL_CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_valid(id_valid),
        .stall(stall), .flush(flush), .pc_write(u0_pcw), .ifid_write(u0_ifw),
        .ex_alu_src(u0_alu_src), .ex_branch(u0_branch), .ex_jal_sel(u0_jal_sel),
        .ex_alu_op(u0_alu_op), .ex_upper(u0_upper), .mem_read(u0_mr), .mem_write(u0_mw),
        .wb_reg_write(u0_wr), .wb_mem_to_reg(u0_wm), .halted(u0_halted), .ill_count(u0_ill)
    );

    pipe_ctrl_unit #(.OPCODE_W(7), .ENABLE_UPPER(1), .ILL_CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_valid(id_valid),
        .stall(stall), .flush(flush), .pc_write(u1_pcw), .ifid_write(u1_ifw),
        .ex_alu_src(u1_alu_src), .ex_branch(u1_branch), .ex_jal_sel(u1_jal_sel),
        .ex_alu_op(u1_alu_op), .ex_upper(u1_upper), .mem_read(u1_mr), .mem_write(u1_mw),
        .wb_reg_write(u1_wr), .wb_mem_to_reg(u1_wm), .halted(u1_halted), .ill_count(u1_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    rec_t sb_q[$];

    // Reference state: slot[k][c] is the bundle that entered EX at edge c.
    ctl_t       slot [2][0:4095];
    int         cyc;
    int         halt_n;
    int         ill [2];
    bit         pv, pst, pfl;
    logic [6:0] pop;

    logic [6:0] op_tab [9] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    function automatic bit ref_legal(logic [6:0] op, bit up);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_HALT) ||
               (up && (op == OP_LUI || op == OP_AUIPC));
    endfunction

    function automatic ctl_t ref_dec(logic [6:0] op, bit up);
        ctl_t c;
        bit r, i, lw, sw, br, jal, jalr, lui, auipc;
        r = (op == OP_R);   i = (op == OP_I);     lw = (op == OP_LW);  sw = (op == OP_SW);
        br = (op == OP_BR); jal = (op == OP_JAL); jalr = (op == OP_JALR);
        lui = up && (op == OP_LUI);
        auipc = up && (op == OP_AUIPC);
        c.alu_src    = lw | sw | i | lui | auipc;
        c.mem_to_reg = lw;
        c.mem_read   = lw;
        c.mem_write  = sw;
        c.reg_write  = r | i | lw | jal | jalr | lui | auipc;
        c.alu_op     = {r | i, br};
        c.branch     = br | jal;
        c.jal_sel    = jal | jalr;
        c.upper      = {auipc, lui};
        return c;
    endfunction

    function automatic obs_t to_obs(ctl_t e, ctl_t m, ctl_t w, int illc, bit hlt, bit fw);
        obs_t o;
        o.ill    = 8'(illc);
        o.halted = hlt;
        o.fetch  = {fw, fw};
        o.ex     = {e.alu_src, e.branch, e.jal_sel, e.alu_op, e.upper};
        o.mem    = {m.mem_read, m.mem_write};
        o.wb     = {w.reg_write, w.mem_to_reg};
        return o;
    endfunction

    function automatic obs_t obs0();
        return '{ill: u0_ill, halted: u0_halted, fetch: {u0_pcw, u0_ifw},
                 ex: {u0_alu_src, u0_branch, u0_jal_sel, u0_alu_op, u0_upper},
                 mem: {u0_mr, u0_mw}, wb: {u0_wr, u0_wm}};
    endfunction

    function automatic obs_t obs1();
        return '{ill: u1_ill, halted: u1_halted, fetch: {u1_pcw, u1_ifw},
                 ex: {u1_alu_src, u1_branch, u1_jal_sel, u1_alu_op, u1_upper},
                 mem: {u1_mr, u1_mw}, wb: {u1_wr, u1_wm}};
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_obs(string who, obs_t act, obs_t exp);
        chk({who, ".ex"},     8'(act.ex),     8'(exp.ex));
        chk({who, ".mem"},    8'(act.mem),    8'(exp.mem));
        chk({who, ".wb"},     8'(act.wb),     8'(exp.wb));
        chk({who, ".fetch"},  8'(act.fetch),  8'(exp.fetch));
        chk({who, ".halted"}, 8'(act.halted), 8'(exp.halted));
        chk({who, ".ill"},    act.ill,        exp.ill);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4096; c++) slot[k][c] = '0;
            ill[k] = 0;
        end
        halt_n = -1;
        pv = 1'b0; pst = 1'b0; pfl = 1'b0; pop = '0;
    endtask

    // One clock: apply the previous cycle's inputs to the model at the edge,
    // drive this cycle's inputs and queue the outputs expected for this cycle.
    task automatic step(bit v, logic [6:0] op, bit st, bit fl);
        bit   frz, take, frz_now;
        rec_t r;
        obs_t o [2];
        @(posedge clk);
        cyc++;
        frz  = (halt_n >= 0) && (cyc - 1 >= halt_n + 1);
        take = !frz && pv && !pst && !pfl;
        for (int k = 0; k < 2; k++) begin
            ctl_t c;
            c = '0;
            if (take && pop != OP_HALT) begin
                if (ref_legal(pop, k == 1)) c = ref_dec(pop, k == 1);
                else if (ill[k] < 255) ill[k]++;
            end
            slot[k][cyc % 4096] = c;
        end
        if (take && pop == OP_HALT && halt_n < 0) halt_n = cyc - 1;
        #1;
        id_valid = v; id_opcode = op; stall = st; flush = fl;
        pv = v; pop = op; pst = st; pfl = fl;
        frz_now = (halt_n >= 0) && (cyc >= halt_n + 1);
        for (int k = 0; k < 2; k++) begin
            o[k] = to_obs(slot[k][cyc % 4096], slot[k][(cyc - 1) % 4096], slot[k][(cyc - 2) % 4096],
                          ill[k], (halt_n >= 0) && (cyc >= halt_n + 4), !frz_now && !st);
        end
        r.u0 = o[0];
        r.u1 = o[1];
        sb_q.push_back(r);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 7'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        obs_t rv;
        rv = '{ill: 8'd0, halted: 1'b0, fetch: 2'b11, ex: 7'd0, mem: 2'd0, wb: 2'd0};
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        id_valid = 1'b0; stall = 1'b0; flush = 1'b0; id_opcode = '0;
        #1;
        cmp_obs("rst0", obs0(), rv);
        cmp_obs("rst1", obs1(), rv);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                cmp_obs("u0", obs0(), r.u0);
                cmp_obs("u1", obs1(), r.u1);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        bit         v, st, fl;
        logic [6:0] op;
        rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; stall = 1'b0; flush = 1'b0;
        cyc = 10;
        model_clear();
        do_reset();

        step(1, OP_LW, 0, 0); step(1, OP_SW, 0, 0); step(1, OP_R, 0, 0);
        step(1, OP_BR, 0, 0); step(1, OP_JAL, 0, 0);
        idle(4);
        step(1, OP_LW, 0, 0); step(1, OP_R, 1, 0); step(1, OP_R, 0, 0);
        idle(3);
        step(1, OP_JALR, 0, 1);
        idle(3);
        step(1, OP_LUI, 0, 0); step(1, OP_AUIPC, 0, 0); step(1, OP_I, 0, 0);
        step(1, OP_LUI, 1, 0); step(1, OP_AUIPC, 0, 1);
        idle(3);

        repeat (400) begin
            v  = ($urandom_range(0, 9) != 0);
            op = ($urandom_range(0, 10) < 9) ? op_tab[$urandom_range(0, 8)] : 7'($urandom);
            if (op == OP_HALT) op = 7'b0000000;
            st = ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 7) == 0);
            step(v, op, st, fl);
        end
        idle(3);

        repeat (300) step(1, OP_LUI, 0, 0);
        idle(2);

        step(1, OP_HALT, 0, 1);
        step(1, OP_R, 0, 0); step(1, OP_I, 0, 0);
        step(1, OP_HALT, 1, 0); step(1, OP_HALT, 0, 0);
        repeat (12) step(1'($urandom), op_tab[$urandom_range(0, 8)],
                         1'($urandom), 1'($urandom));

        do_reset();
        step(1, OP_R, 0, 0); step(1, OP_I, 0, 0); step(1, OP_HALT, 0, 0);
        idle(1);
        do_reset();
        step(1, OP_LW, 0, 0); step(1, OP_SW, 0, 0); step(1, OP_BR, 0, 0);
        idle(4);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain got=%0d want=0", sb_q.size());
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered, pipelined successor to the single-cycle opcode decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts bubbles on load-use stalls and branch flushes, and runs a halt state machine that drains the pipeline before freezing fetch. It sits between the IF/ID register and the datapath stage registers of the 5-stage core.

## Interface
Parameters:
- OPCODE_W, 7, opcode field width
- ENABLE_UPPER, 1, when 1 decode LUI (0110111) and AUIPC (0010111); when 0 they are illegal
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  OPCODE_W  opcode of the instruction in IF/ID
- id_valid  in  1  IF/ID holds a real instruction
- stall  in  1  load-use hazard from hazard unit
- flush  in  1  taken branch/jump resolved in EX
- pc_write, ifid_write  out  1 each  fetch/IF-ID enables
- ex_alu_src, ex_branch, ex_jal_sel  out  1 each  EX-stage controls
- ex_alu_op  out  2  00 load/store/upper, 01 branch, 10 R/I-type
- ex_upper  out  2  00 none, 01 LUI, 10 AUIPC
- mem_read, mem_write  out  1 each  MEM-stage controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
- halted  out  1  pipeline drained and frozen
- ill_count  out  ILL_CNT_W  illegal opcodes decoded, saturating

## Operation
- Decode is combinational on id_opcode. Recognised opcodes:
  - R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, HALT 1111111, plus LUI/AUIPC per ENABLE_UPPER.
- Signal rules:
  - alu_src: LW, SW, I, LUI, AUIPC
  - mem_to_reg, mem_read: LW
  - mem_write: SW
  - reg_write: R, I, LW, JAL, JALR, LUI, AUIPC
  - alu_op[0]: BR
  - alu_op[1]: R, I
  - branch: BR, JAL
  - jal_sel: JAL, JALR
- Unrecognised opcode with id_valid=1: the bundle becomes a bubble (all zeros) and ill_count increments, saturating at all-ones. The counter is not incremented while stall or flush is high.
- Each stage register holds its bundle and a valid bit. The ex_*, mem_* and wb_* outputs are the registered bundle gated by that stage's valid bit.
- Priority into ID/EX, highest first: flush, stall, HALT, normal.
  - flush or stall: a bubble enters ID/EX.
  - HALT: a bubble enters ID/EX.
  - normal: the decoded bundle enters ID/EX.
- EX/MEM and MEM/WB always advance; they are never stalled.
- pc_write = ifid_write = (state==RUN) & ~stall. flush does not clear ifid_write; the IF/ID flush is owned by the hazard unit.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when id_valid & HALT & ~stall & ~flush. Load a 2-bit drain counter with 2.
  - DRAIN: fetch is frozen, a bubble is inserted every cycle, and flush and stall are ignored. Decrement the counter each cycle; go to HALTED in the cycle after the counter reads 0, when all stage valids are clear.
  - HALTED: sticky until rst_n. Fetch stays frozen, all stage outputs are 0, and halted=1.
- HALT arriving while stall=1 stays in ID and is taken once stall drops. HALT arriving with flush=1 is discarded and the FSM stays in RUN.

## Timing
- Reset values:
  - All stage registers and valids 0, so every ex_/mem_/wb_ output is 0.
  - state RUN, halted 0, ill_count 0, pc_write=ifid_write=1.
- Latency for an opcode decoded in ID at edge n: ex_* visible after edge n+1, mem_* after n+2, wb_* after n+3.
- stall and flush act at the same edge as the opcode they accompany.
- HALT decoded at edge n:
  - pc_write falls combinationally after edge n+1 (state DRAIN).
  - Instructions older than HALT complete WB by edge n+3.
  - halted rises after edge n+4.
- rst_n asserted mid-operation clears all state asynchronously. Outputs return to reset values without waiting for clk. Deassertion is synchronised externally.

## Test plan
- Sequence LW, SW, R, BR, JAL with no hazards:
  - LW gives ex_alu_src=1 at n+1, mem_read=1 at n+2, wb_mem_to_reg=1 and wb_reg_write=1 at n+3.
  - SW gives mem_write=1 only; BR gives ex_alu_op=01 and ex_branch=1.
- LW followed by R with stall=1 for one cycle: one all-zero EX slot and pc_write=0 that cycle; the R bundle appears in EX one cycle later.
- flush=1 while JALR is in ID: ex_* = 0 next cycle and wb_reg_write stays 0 for that slot.
- ENABLE_UPPER=0, opcode 0110111: bubble and ill_count=1. Repeat 300 times with ILL_CNT_W=8: ill_count saturates at 255.
- R, I, HALT: both older instructions reach wb_reg_write=1, pc_write=0 from n+1, halted=1 after n+4, and it stays halted through later flush and stall pulses.
- rst_n pulsed low in DRAIN: immediate return to RUN with halted=0, pc_write=1 and all outputs 0.
